// File: rtl/prog_delay_line.sv
// prog_delay_line
//   Run-time programmable delay line. A WIDTH-bit word is delayed by
//   cur_delay enabled cycles, where cur_delay is between 1 and MAX_DELAY.
//   The delay can be reloaded while the line is running. data_valid_o shows
//   when data_o holds real pushed history rather than reset or flush fill.
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   srst_i        synchronous reset, active-high
//   en_i          shift enable: capture data_i and advance the line
//   data_i        input word
//   flush_i       discard history (fill count to 0); data registers keep their contents
//   delay_we_i    load the clamped delay_i into the active delay register
//   delay_i       requested delay (0 -> 1, above MAX_DELAY -> MAX_DELAY)
//   data_o        word pushed cur_delay enabled cycles earlier
//   data_valid_o  high when the fill count is at least cur_delay
//   cur_delay_o   active (clamped) delay
module prog_delay_line #(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 10,
  localparam int DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             flush_i,
  input  logic             delay_we_i,
  input  logic [DW-1:0]    delay_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid_o,
  output logic [DW-1:0]    cur_delay_o
);

  logic [WIDTH-1:0] stage_q [MAX_DELAY];
  logic [DW-1:0]    fillCnt_q, fillCnt_d;
  logic [DW-1:0]    curDelay_q, curDelay_d;

  // Clamp the requested delay into the legal range 1..MAX_DELAY.
  always_comb begin
    curDelay_d = curDelay_q;
    if (delay_we_i) begin
      if (delay_i == '0) begin
        curDelay_d = DW'(1);
      end else if (delay_i > DW'(MAX_DELAY)) begin
        curDelay_d = DW'(MAX_DELAY);
      end else begin
        curDelay_d = delay_i;
      end
    end
  end

  // Flush wins over counting. A word pushed on the flush cycle is the first
  // word of the new history, so it counts as 1. The count saturates.
  always_comb begin
    fillCnt_d = fillCnt_q;
    if (flush_i) begin
      fillCnt_d = en_i ? DW'(1) : '0;
    end else if (en_i && (fillCnt_q < DW'(MAX_DELAY))) begin
      fillCnt_d = fillCnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        stage_q[k] <= '0;
      end
      fillCnt_q  <= '0;
      curDelay_q <= DW'(DEFAULT_DELAY);
    end else begin
      if (en_i) begin
        stage_q[0] <= data_i;
        for (int k = 1; k < MAX_DELAY; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
      fillCnt_q  <= fillCnt_d;
      curDelay_q <= curDelay_d;
    end
  end

  // Output tap: stage[cur_delay-1], selected by a one-hot compare. This avoids
  // an arithmetic index that is wider than the stage array needs.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (curDelay_q == DW'(k + 1)) begin
        data_o = stage_q[k];
      end
    end
  end

  assign data_valid_o = (fillCnt_q >= curDelay_q);
  assign cur_delay_o  = curDelay_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line
//   Self-checking bench for prog_delay_line with the default parameters
//   (WIDTH 8, MAX_DELAY 16, DEFAULT_DELAY 10). Each driven cycle updates a
//   behavioural model built on a log of every pushed word. The expected
//   outputs are queued, then popped and compared at the following falling edge.
module tb_prog_delay_line;

  localparam int WIDTH = 8;
  localparam int MAXD  = 16;
  localparam int DW    = 5;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic             en_i;
  logic [WIDTH-1:0] data_i;
  logic             flush_i;
  logic             delay_we_i;
  logic [DW-1:0]    delay_i;
  logic [WIDTH-1:0] data_o;
  logic             data_valid_o;
  logic [DW-1:0]    cur_delay_o;

  always #5 clk_i = ~clk_i;

  prog_delay_line dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .en_i         (en_i),
    .data_i       (data_i),
    .flush_i      (flush_i),
    .delay_we_i   (delay_we_i),
    .delay_i      (delay_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .cur_delay_o  (cur_delay_o)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic [DW-1:0]    dly;
  } obsT;

  obsT              expQ[$];
  logic [WIDTH-1:0] pushLog[$];
  int               nPush;
  int               fillM;
  int               dM;
  int               checksPassed;
  int               checksTotal;

  // Drives one cycle of stimulus and updates the model at the rising edge.
  // Then it queues the expected outputs and returns at the next falling edge.
  task automatic doCycle(input logic en, input logic [WIDTH-1:0] d, input logic fl,
                         input logic we, input logic [DW-1:0] dl, input logic rst);
    obsT e;
    srst_i     = rst;
    en_i       = en;
    data_i     = d;
    flush_i    = fl;
    delay_we_i = we;
    delay_i    = dl;
    @(posedge clk_i);
    if (rst) begin
      pushLog.delete();
      nPush = 0;
      fillM = 0;
      dM    = 10;
    end else begin
      if (we) dM = (dl == 0) ? 1 : ((int'(dl) > MAXD) ? MAXD : int'(dl));
      if (en) begin
        pushLog.push_back(d);
        nPush++;
      end
      if (fl) fillM = en ? 1 : 0;
      else if (en && fillM < MAXD) fillM++;
    end
    e.data  = (nPush >= dM) ? pushLog[nPush - dM] : '0;
    e.valid = (fillM >= dM);
    e.dly   = DW'(dM);
    expQ.push_back(e);
    @(negedge clk_i);
    srst_i     = 1'b0;
    en_i       = 1'b0;
    flush_i    = 1'b0;
    delay_we_i = 1'b0;
  endtask

  task automatic test_reset();
    obsT e;
    doCycle(1'b1, 8'h55, 1'b1, 1'b1, 5'd3, 1'b1);
    e = expQ.pop_front();
    checksTotal++;
    if ({data_o, data_valid_o, cur_delay_o} !== {8'd0, 1'b0, 5'd10}) begin
      $display("[TB] FAIL reset_state: got data=%0d valid=%0d dly=%0d, want 0/0/10",
               data_o, data_valid_o, cur_delay_o);
    end else begin
      checksPassed++;
    end
    checksTotal++;
    if ({data_o, data_valid_o, cur_delay_o} !== e) begin
      $display("[TB] FAIL reset_model: got %h want %h", {data_o, data_valid_o, cur_delay_o}, e);
    end else begin
      checksPassed++;
    end
  endtask

  // Streaming with the default delay, then shortening the delay after fill,
  // then lengthening it to 16 once the fill count has dropped to 12.
  task automatic test_stream_and_load();
    obsT e;
    for (int i = 1; i <= 44; i++) begin
      if (i <= 24)      doCycle(1'b1, 8'(i), 1'b0, 1'b0, 5'd0, 1'b0);
      else if (i == 25) doCycle(1'b1, 8'(i), 1'b0, 1'b1, 5'd3, 1'b0);
      else if (i == 28) doCycle(1'b1, 8'(i), 1'b1, 1'b0, 5'd0, 1'b0);
      else if (i == 40) doCycle(1'b0, 8'(i), 1'b0, 1'b1, 5'd16, 1'b0);
      else              doCycle(1'b1, 8'(i), 1'b0, 1'b0, 5'd0, 1'b0);
      e = expQ.pop_front();
      checksTotal++;
      if ({data_o, data_valid_o, cur_delay_o} !== e) begin
        $display("[TB] FAIL stream step %0d: got data=%0d valid=%0d dly=%0d, want data=%0d valid=%0d dly=%0d",
                 i, data_o, data_valid_o, cur_delay_o, e.data, e.valid, e.dly);
      end else begin
        checksPassed++;
      end
      if (i == 10 || i == 40) begin
        checksTotal++;
        if ({data_o, data_valid_o} !== ((i == 10) ? {8'd1, 1'b1} : {8'd24, 1'b0})) begin
          $display("[TB] FAIL stream_edge step %0d: got data=%0d valid=%0d", i, data_o, data_valid_o);
        end else begin
          checksPassed++;
        end
      end
    end
  endtask

  task automatic test_clamp();
    obsT e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       doCycle(1'b1, 8'hA5, 1'b0, 1'b1, 5'd0, 1'b0);
        1:       doCycle(1'b1, 8'h3C, 1'b0, 1'b1, 5'd31, 1'b0);
        2:       doCycle(1'b1, 8'h77, 1'b0, 1'b1, 5'd17, 1'b0);
        default: doCycle(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0);
      endcase
      e = expQ.pop_front();
      checksTotal++;
      if ({data_o, data_valid_o, cur_delay_o} !== e) begin
        $display("[TB] FAIL clamp step %0d: got data=%0d valid=%0d dly=%0d, want data=%0d valid=%0d dly=%0d",
                 i, data_o, data_valid_o, cur_delay_o, e.data, e.valid, e.dly);
      end else begin
        checksPassed++;
      end
      if (i == 0) begin
        checksTotal++;
        if ({data_o, cur_delay_o} !== {8'hA5, 5'd1}) begin
          $display("[TB] FAIL clamp_zero: got data=%h dly=%0d, want a5/1", data_o, cur_delay_o);
        end else begin
          checksPassed++;
        end
      end
    end
  endtask

  task automatic test_enable();
    obsT e;
    logic en;
    doCycle(1'b0, 8'h00, 1'b0, 1'b1, 5'd5, 1'b0);
    void'(expQ.pop_front());
    for (int i = 0; i < 36; i++) begin
      en = (i < 16) ? ((i % 3) == 0) : 1'b0;
      doCycle(en, 8'(8'h80 + i), 1'b0, 1'b0, 5'd0, 1'b0);
      e = expQ.pop_front();
      checksTotal++;
      if ({data_o, data_valid_o, cur_delay_o} !== e) begin
        $display("[TB] FAIL enable step %0d: got data=%0d valid=%0d dly=%0d, want data=%0d valid=%0d dly=%0d",
                 i, data_o, data_valid_o, cur_delay_o, e.data, e.valid, e.dly);
      end else begin
        checksPassed++;
      end
    end
  endtask

  task automatic test_flush();
    obsT e;
    for (int i = 0; i < 26; i++) begin
      if (i == 0)       doCycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 5'd4, 1'b0);
      else if (i == 20) doCycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 5'd0, 1'b0);
      else if (i == 24) doCycle(1'b0, 8'(8'h40 + i), 1'b1, 1'b0, 5'd0, 1'b0);
      else              doCycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 5'd0, 1'b0);
      e = expQ.pop_front();
      checksTotal++;
      if ({data_o, data_valid_o, cur_delay_o} !== e) begin
        $display("[TB] FAIL flush step %0d: got data=%0d valid=%0d dly=%0d, want data=%0d valid=%0d dly=%0d",
                 i, data_o, data_valid_o, cur_delay_o, e.data, e.valid, e.dly);
      end else begin
        checksPassed++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    obsT e;
    for (int i = 0; i < 8; i++) begin
      doCycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 5'd0, (i == 5));
      if (i == 5) begin
        doCycle(1'b1, 8'hEE, 1'b0, 1'b1, 5'd3, 1'b1);
        void'(expQ.pop_front());
        checksTotal++;
        if ({data_o, data_valid_o, cur_delay_o} !== {8'd0, 1'b0, 5'd10}) begin
          $display("[TB] FAIL reset_midstream: got data=%0d valid=%0d dly=%0d, want 0/0/10",
                   data_o, data_valid_o, cur_delay_o);
        end else begin
          checksPassed++;
        end
      end
      e = expQ.pop_front();
      if (i != 5) begin
        checksTotal++;
        if ({data_o, data_valid_o, cur_delay_o} !== e) begin
          $display("[TB] FAIL post_reset step %0d: got data=%0d valid=%0d dly=%0d, want data=%0d valid=%0d dly=%0d",
                   i, data_o, data_valid_o, cur_delay_o, e.data, e.valid, e.dly);
        end else begin
          checksPassed++;
        end
      end
    end
  endtask

  task automatic test_random();
    obsT e;
    for (int i = 0; i < 300; i++) begin
      doCycle(($urandom_range(9, 0) < 7), 8'($urandom), ($urandom_range(9, 0) == 0),
              ($urandom_range(7, 0) == 0), 5'($urandom_range(31, 0)),
              ($urandom_range(59, 0) == 0));
      e = expQ.pop_front();
      checksTotal++;
      if ({data_o, data_valid_o, cur_delay_o} !== e) begin
        $display("[TB] FAIL random step %0d: got data=%0d valid=%0d dly=%0d, want data=%0d valid=%0d dly=%0d",
                 i, data_o, data_valid_o, cur_delay_o, e.data, e.valid, e.dly);
      end else begin
        checksPassed++;
      end
    end
  endtask

  initial begin
    srst_i       = 1'b1;
    en_i         = 1'b0;
    data_i       = '0;
    flush_i      = 1'b0;
    delay_we_i   = 1'b0;
    delay_i      = '0;
    nPush        = 0;
    fillM        = 0;
    dM           = 10;
    checksPassed = 0;
    checksTotal  = 0;
    test_reset();
    test_stream_and_load();
    test_clamp();
    test_enable();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
